controle_rodada: RTL

- Control unit for the play phase of MindFocus.
- Per round it:
  - fetches the target pattern from pattern memory;
  - registers it for the move comparator;
  - waits for a single button press (edge-detected) or a timeout;
  - samples the comparator's hit flag and updates hit/miss counters.
- After N_RODADAS rounds it raises fim.
- Sits between the pattern ROM, the button inputs and the comparator; drives the comparator's A and B operands and consumes its acerto result.

---
 rtl/controle_rodada.sv | 110 +++++++++++
 1 files changed

// File: rtl/controle_rodada.sv
// Play-phase controller for MindFocus: fetch pattern, wait for one press or timeout, score, repeat N_RODADAS times.
// Press sampled at edge t updates pontos/erros one edge after COMPARA is entered; all outputs registered or state-decoded.
module controle_rodada #(
  parameter int N_RODADAS = 16,
  parameter int TIMEOUT   = 2000,
  parameter int LARG_CONT = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic [7:0]           padrao,
  input  logic [3:0]           botoes,
  input  logic                 acerto,
  output logic [3:0]           endereco,
  output logic [7:0]           padrao_reg,
  output logic [3:0]           jogada_reg,
  output logic [LARG_CONT-1:0] pontos,
  output logic [LARG_CONT-1:0] erros,
  output logic                 esgotou,
  output logic                 pronto,
  output logic                 fim,
  output logic [3:0]           estado_db
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CARREGA = 3'd1;
  localparam logic [2:0] ESPERA  = 3'd2;
  localparam logic [2:0] COMPARA = 3'd3;
  localparam logic [2:0] PROXIMA = 3'd4;
  localparam logic [2:0] FIM     = 3'd5;

  localparam int              TW        = $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TIMER_FIM = TW'(TIMEOUT - 1);
  localparam logic [3:0]      ULTIMA    = 4'(N_RODADAS - 1);

  logic [2:0]    estado;
  logic [TW-1:0] timer;
  logic [3:0]    botoes_ant;
  logic          evento;
  logic          jogada_unica;

  // Only a rising transition from "nothing pressed" counts, so a held button never re-triggers.
  assign evento       = (botoes_ant == 4'd0) && (botoes != 4'd0);
  assign jogada_unica = (jogada_reg != 4'd0) && ((jogada_reg & (jogada_reg - 4'd1)) == 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= IDLE;
      endereco   <= '0;
      padrao_reg <= '0;
      jogada_reg <= '0;
      pontos     <= '0;
      erros      <= '0;
      timer      <= '0;
      botoes_ant <= '0;
      esgotou    <= 1'b0;
    end else begin
      botoes_ant <= botoes;
      esgotou    <= 1'b0;
      case (estado)
        IDLE, FIM: begin
          if (iniciar) begin
            pontos   <= '0;
            erros    <= '0;
            endereco <= '0;
            timer    <= '0;
            estado   <= CARREGA;
          end
        end
        CARREGA: begin
          padrao_reg <= padrao;
          jogada_reg <= '0;
          timer      <= '0;
          estado     <= ESPERA;
        end
        ESPERA: begin
          timer <= timer + 1'b1;
          // A press on the last allowed cycle beats the timeout.
          if (evento) begin
            jogada_reg <= botoes;
            estado     <= COMPARA;
          end else if (timer == TIMER_FIM) begin
            jogada_reg <= '0;
            esgotou    <= 1'b1;
            estado     <= COMPARA;
          end
        end
        COMPARA: begin
          if (acerto && jogada_unica) pontos <= pontos + 1'b1;
          else                        erros  <= erros + 1'b1;
          estado <= PROXIMA;
        end
        PROXIMA: begin
          if (endereco == ULTIMA) begin
            estado <= FIM;
          end else begin
            endereco <= endereco + 1'b1;
            estado   <= CARREGA;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

  assign pronto    = (estado == IDLE);
  assign fim       = (estado == FIM);
  assign estado_db = {1'b0, estado};

endmodule
